// File: rtl/multicycle_datapath.sv
// Multi-cycle LEGv8-subset datapath: one shared ALU, 32-entry register file, unified req/ack memory port.
// Optional feature: define MCDP_CBNZ_EN to decode CBNZ; without it CBNZ retires as an illegal NOP.
module multicycle_datapath #(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] PC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic [XLEN-1:0] pc,
   output logic [2:0]      state,
   output logic            retire,
   output logic            illegal
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_CBNZ, OP_B, OP_ILL
   } op_t;

   typedef enum logic [1:0] {FN_ADD, FN_SUB, FN_AND, FN_ORR} fn_t;

   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   state_t          st;
   logic [31:0]     ir;
   logic [XLEN-1:0] a_q, b_q, alu_out_q, mdr_q;
   // Entry 31 is reset to zero and never written, so XZR reads need no special case.
   logic [XLEN-1:0] rf [0:31];

   op_t             op;
   fn_t             fn;
   logic            is_rtype;
   logic            br_taken;
   logic [XLEN-1:0] d_off, cb_off, b_off;
   logic [XLEN-1:0] alu_x, alu_y, alu_r;

   assign state    = st;
   assign d_off    = {{(XLEN-9){ir[20]}}, ir[20:12]};
   assign cb_off   = {{(XLEN-21){ir[23]}}, ir[23:5], 2'b00};
   assign b_off    = {{(XLEN-28){ir[25]}}, ir[25:0], 2'b00};
   assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);

   always_comb begin
      op = OP_ILL;
      if      (ir[31:21] == 11'b10001011000) op = OP_ADD;
      else if (ir[31:21] == 11'b11001011000) op = OP_SUB;
      else if (ir[31:21] == 11'b10001010000) op = OP_AND;
      else if (ir[31:21] == 11'b10101010000) op = OP_ORR;
      else if (ir[31:21] == 11'b11111000010) op = OP_LDUR;
      else if (ir[31:21] == 11'b11111000000) op = OP_STUR;
      else if (ir[31:24] == 8'b10110100)     op = OP_CBZ;
`ifdef MCDP_CBNZ_EN
      else if (ir[31:24] == 8'b10110101)     op = OP_CBNZ;
`endif
      else if (ir[31:26] == 6'b000101)       op = OP_B;
   end

   always_comb begin
      br_taken = 1'b0;
      if (op == OP_CBZ)       br_taken = (b_q == '0);
      else if (op == OP_CBNZ) br_taken = (b_q != '0);
   end

   // Outside EXEC the ALU computes pc+4, which every retiring state needs.
   always_comb begin
      alu_x = pc;
      alu_y = FOUR;
      fn    = FN_ADD;
      if (st == S_EXEC) begin
         case (op)
            OP_ADD:           begin alu_x = a_q; alu_y = b_q; end
            OP_SUB:           begin alu_x = a_q; alu_y = b_q; fn = FN_SUB; end
            OP_AND:           begin alu_x = a_q; alu_y = b_q; fn = FN_AND; end
            OP_ORR:           begin alu_x = a_q; alu_y = b_q; fn = FN_ORR; end
            OP_LDUR, OP_STUR: begin alu_x = a_q; alu_y = d_off; end
            OP_CBZ, OP_CBNZ:  alu_y = br_taken ? cb_off : FOUR;
            OP_B:             alu_y = b_off;
            default:          ;
         endcase
      end
   end

   always_comb begin
      case (fn)
         FN_SUB:  alu_r = alu_x - alu_y;
         FN_AND:  alu_r = alu_x & alu_y;
         FN_ORR:  alu_r = alu_x | alu_y;
         default: alu_r = alu_x + alu_y;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= S_FETCH;
         pc        <= PC_RESET;
         ir        <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         mdr_q     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         retire    <= 1'b0;
         illegal   <= 1'b0;
         for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         retire  <= 1'b0;
         illegal <= 1'b0;
         case (st)
            S_FETCH: begin
               // Requests are normally raised on entry; this covers the first fetch after reset.
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ack) begin
                  ir      <= mem_rdata[31:0];
                  mem_req <= 1'b0;
                  st      <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q <= rf[ir[9:5]];
               b_q <= is_rtype ? rf[ir[20:16]] : rf[ir[4:0]];
               if (op == OP_ILL) begin
                  illegal  <= 1'b1;
                  retire   <= 1'b1;
                  pc       <= alu_r;
                  st       <= S_FETCH;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= alu_r;
               end else begin
                  st <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                     alu_out_q <= alu_r;
                     st        <= S_WB;
                  end
                  OP_LDUR, OP_STUR: begin
                     alu_out_q <= alu_r;
                     mem_req   <= 1'b1;
                     mem_we    <= (op == OP_STUR);
                     mem_addr  <= alu_r;
                     if (op == OP_STUR) mem_wdata <= b_q;
                     st        <= S_MEM;
                  end
                  default: begin
                     pc       <= alu_r;
                     retire   <= 1'b1;
                     st       <= S_FETCH;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= alu_r;
                  end
               endcase
            end
            S_MEM: begin
               if (mem_ack) begin
                  if (mem_we) begin
                     pc       <= alu_r;
                     retire   <= 1'b1;
                     st       <= S_FETCH;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= alu_r;
                  end else begin
                     mdr_q   <= mem_rdata;
                     mem_req <= 1'b0;
                     st      <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (ir[4:0] != 5'd31) rf[ir[4:0]] <= (op == OP_LDUR) ? mdr_q : alu_out_q;
               pc       <= alu_r;
               retire   <= 1'b1;
               st       <= S_FETCH;
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= alu_r;
            end
            default: begin
               st      <= S_FETCH;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed-vector bench for multicycle_datapath: behavioural req/ack memory with programmable ack delay.
module tb_multicycle_datapath;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_we, mem_ack;
   logic [63:0] mem_addr, mem_wdata, mem_rdata, pc;
   logic [2:0]  state;
   logic        retire, illegal;

   int total = 0;
   int bad   = 0;

`ifdef MCDP_CBNZ_EN
   localparam bit CBNZ_ON = 1'b1;
`else
   localparam bit CBNZ_ON = 1'b0;
`endif

   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
   localparam logic [63:0] JUNK     = 64'hDEAD_BEEF_0BAD_F00D;

   multicycle_datapath #(.XLEN(64), .PC_RESET(64'h0)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .pc(pc), .state(state), .retire(retire), .illegal(illegal)
   );

   always #5 clk = ~clk;

   logic [63:0] mem [logic [63:0]];
   int          ack_delay = 0;
   int          wcnt = 0;
   int unsigned cyc = 0;
   logic [63:0] st_addr_q [$];
   logic [63:0] st_data_q [$];
   logic [63:0] ret_pc_q  [$];
   logic        ret_ill_q [$];
   int unsigned ret_cyc_q [$];

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = JUNK;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder plus retire/store logging, all evaluated on the falling edge.
   always @(negedge clk) begin
      if (!rst || !mem_req) begin
         mem_ack   <= 1'b0;
         mem_rdata <= JUNK;
         wcnt      <= 0;
      end else if (wcnt >= ack_delay) begin
         mem_ack <= 1'b1;
         wcnt    <= 0;
         if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            st_addr_q.push_back(mem_addr);
            st_data_q.push_back(mem_wdata);
            mem_rdata <= JUNK;
         end else begin
            mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
         end
      end else begin
         mem_ack   <= 1'b0;
         mem_rdata <= JUNK;
         wcnt      <= wcnt + 1;
      end
      if (rst && retire) begin
         ret_cyc_q.push_back(cyc);
         ret_pc_q.push_back(pc);
         ret_ill_q.push_back(illegal);
      end
   end

   function automatic logic [31:0] r_op(input logic [10:0] opc, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
      return {opc, rm, 6'd0, rn, rd};
   endfunction

   function automatic logic [31:0] d_op(input logic [10:0] opc, input logic [8:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rt);
      return {opc, imm, 2'b00, rn, rt};
   endfunction

   function automatic logic [31:0] cb_op(input logic [7:0] opc, input logic [18:0] imm,
                                         input logic [4:0] rt);
      return {opc, imm, rt};
   endfunction

   function automatic logic [31:0] b_op(input logic [25:0] imm);
      return {6'b000101, imm};
   endfunction

   task automatic put(input logic [63:0] a, input logic [31:0] w);
      mem[a] = {32'h0, w};
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      ack_delay = 0;
      @(negedge clk);
      mem.delete();
      st_addr_q.delete();
      st_data_q.delete();
      ret_pc_q.delete();
      ret_ill_q.delete();
      ret_cyc_q.delete();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_retires(input int n, input int budget, input string name);
      int c = 0;
      while (ret_cyc_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      total++;
      if (ret_cyc_q.size() < n) begin
         bad++;
         $display("FAIL %s_timeout: retires=%0d required=%0d", name, ret_cyc_q.size(), n);
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      @(negedge clk);
      total++;
      if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++;
      if (pc !== 64'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", pc); end
      total++;
      if ({mem_req, mem_we, retire, illegal} !== 4'b0000) begin
         bad++; $display("FAIL reset_ctl: got req/we/ret/ill=%b want 0000", {mem_req, mem_we, retire, illegal});
      end
      total++;
      if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
         bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
      end
      put(64'h0, b_op(26'd4));
      ack_delay = 2;
      @(negedge clk);
      rst = 1'b1;
      run_retires(1, 50, "reset_b");
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h10 || pc !== 64'h10) begin
         bad++; $display("FAIL reset_prefetch: got req=%b addr=%h pc=%h want 1 10 10", mem_req, mem_addr, pc);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0 || pc !== 64'h0 || state !== 3'd0) begin
         bad++; $display("FAIL reset_midfetch: got req=%b pc=%h state=%0d want 0 0 0", mem_req, pc, state);
      end
   endtask

   task automatic test_alu_mem();
      logic [63:0] ea [5] = '{64'd13, 64'h90, 64'h98, 64'hA0, 64'hA8};
      logic [63:0] ed [5] = '{64'd12, 64'd12, 64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 64'd13};
      int          li [5] = '{1, 2, 3, 4, 6};
      int          lv [5] = '{5, 4, 4, 5, 4};
      reset_dut();
      mem[64'h80] = 64'd5;
      mem[64'h88] = 64'd7;
      put(64'h00, d_op(OPC_LDUR, 9'h80, 5'd31, 5'd2));
      put(64'h04, d_op(OPC_LDUR, 9'h88, 5'd31, 5'd3));
      put(64'h08, r_op(OPC_ADD, 5'd3, 5'd2, 5'd1));
      put(64'h0C, d_op(OPC_STUR, 9'd8, 5'd2, 5'd1));
      put(64'h10, d_op(OPC_LDUR, 9'd8, 5'd2, 5'd4));
      put(64'h14, d_op(OPC_STUR, 9'h90, 5'd31, 5'd4));
      put(64'h18, r_op(OPC_SUB, 5'd3, 5'd2, 5'd5));
      put(64'h1C, r_op(OPC_AND, 5'd1, 5'd2, 5'd6));
      put(64'h20, r_op(OPC_ORR, 5'd1, 5'd2, 5'd7));
      put(64'h24, d_op(OPC_STUR, 9'h98, 5'd31, 5'd5));
      put(64'h28, d_op(OPC_STUR, 9'hA0, 5'd31, 5'd6));
      put(64'h2C, d_op(OPC_STUR, 9'hA8, 5'd31, 5'd7));
      run_retires(12, 200, "alu");
      total++;
      if (st_addr_q.size() !== 5) begin bad++; $display("FAIL alu_store_count: got %0d want 5", st_addr_q.size()); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (st_addr_q[i] !== ea[i] || st_data_q[i] !== ed[i]) begin
            bad++; $display("FAIL alu_store%0d: got addr=%h data=%h want addr=%h data=%h",
                            i, st_addr_q[i], st_data_q[i], ea[i], ed[i]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (int'(ret_cyc_q[li[i]] - ret_cyc_q[li[i]-1]) !== lv[i]) begin
            bad++; $display("FAIL alu_latency%0d: got %0d want %0d", li[i],
                            int'(ret_cyc_q[li[i]] - ret_cyc_q[li[i]-1]), lv[i]);
         end
      end
      total++;
      if (ret_pc_q[2] !== 64'h0C || ret_ill_q[2] !== 1'b0) begin
         bad++; $display("FAIL alu_add_pc: got pc=%h ill=%b want 0c 0", ret_pc_q[2], ret_ill_q[2]);
      end
   endtask

   task automatic test_fetch_wait();
      int c = 0;
      reset_dut();
      ack_delay = 3;
      mem[64'h80] = 64'd5;
      put(64'h00, d_op(OPC_LDUR, 9'h80, 5'd31, 5'd2));
      put(64'h04, d_op(OPC_STUR, 9'h90, 5'd31, 5'd2));
      @(negedge clk);
      while (mem_req !== 1'b1 && c < 20) begin
         @(negedge clk);
         c++;
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem_req !== 1'b1 || mem_addr !== 64'h0 || mem_we !== 1'b0 || state !== 3'd0) begin
            bad++; $display("FAIL wait_hold%0d: got req=%b addr=%h we=%b state=%0d want 1 0 0 0",
                            i, mem_req, mem_addr, mem_we, state);
         end
         if (i < 3) @(negedge clk);
      end
      @(posedge clk);
      #1;
      total++;
      if (state !== 3'd1 || mem_req !== 1'b0) begin
         bad++; $display("FAIL wait_decode: got state=%0d req=%b want 1 0", state, mem_req);
      end
      run_retires(2, 200, "wait");
      total++;
      if (st_addr_q[0] !== 64'h90 || st_data_q[0] !== 64'd5) begin
         bad++; $display("FAIL wait_store: got addr=%h data=%h want 90 5", st_addr_q[0], st_data_q[0]);
      end
      total++;
      if (int'(ret_cyc_q[1] - ret_cyc_q[0]) !== 10) begin
         bad++; $display("FAIL wait_stur_latency: got %0d want 10", int'(ret_cyc_q[1] - ret_cyc_q[0]));
      end
   endtask

   task automatic test_branch();
      logic [63:0] ep [5] = '{64'h40, 64'h38, 64'h3C, 64'h40, 64'h44};
      reset_dut();
      mem[64'hB0] = 64'd1;
      put(64'h00, b_op(26'd16));
      put(64'h40, cb_op(OPC_CBZ, 19'h7FFFE, 5'd5));
      put(64'h38, d_op(OPC_LDUR, 9'hB0, 5'd31, 5'd5));
      put(64'h3C, b_op(26'd1));
      run_retires(5, 200, "branch");
      for (int i = 0; i < 5; i++) begin
         total++;
         if (ret_pc_q[i] !== ep[i]) begin
            bad++; $display("FAIL branch_pc%0d: got %h want %h", i, ret_pc_q[i], ep[i]);
         end
      end
      total++;
      if (int'(ret_cyc_q[1] - ret_cyc_q[0]) !== 3 || int'(ret_cyc_q[4] - ret_cyc_q[3]) !== 3) begin
         bad++; $display("FAIL branch_latency: got taken=%0d nottaken=%0d want 3 3",
                         int'(ret_cyc_q[1] - ret_cyc_q[0]), int'(ret_cyc_q[4] - ret_cyc_q[3]));
      end
   endtask

   task automatic test_wrap_illegal();
      reset_dut();
      put(64'h00, b_op(26'h3FF_FFFF));
      run_retires(2, 100, "wrap");
      total++;
      if (ret_pc_q[0] !== 64'hFFFF_FFFF_FFFF_FFFC || ret_ill_q[0] !== 1'b0) begin
         bad++; $display("FAIL wrap_pc: got pc=%h ill=%b want fffffffffffffffc 0", ret_pc_q[0], ret_ill_q[0]);
      end
      total++;
      if (ret_ill_q[1] !== 1'b1 || ret_pc_q[1] !== 64'h0) begin
         bad++; $display("FAIL illegal_op0: got ill=%b pc=%h want 1 0", ret_ill_q[1], ret_pc_q[1]);
      end
      total++;
      if (int'(ret_cyc_q[1] - ret_cyc_q[0]) !== 2) begin
         bad++; $display("FAIL illegal_latency: got %0d want 2", int'(ret_cyc_q[1] - ret_cyc_q[0]));
      end
   endtask

   task automatic test_xzr();
      reset_dut();
      mem[64'h80] = 64'd5;
      put(64'h00, d_op(OPC_LDUR, 9'h80, 5'd31, 5'd1));
      put(64'h04, r_op(OPC_ADD, 5'd1, 5'd1, 5'd31));
      put(64'h08, d_op(OPC_STUR, 9'h90, 5'd31, 5'd31));
      put(64'h0C, r_op(OPC_ADD, 5'd1, 5'd31, 5'd8));
      put(64'h10, d_op(OPC_STUR, 9'h98, 5'd31, 5'd8));
      run_retires(5, 200, "xzr");
      total++;
      if (st_addr_q[0] !== 64'h90 || st_data_q[0] !== 64'd0) begin
         bad++; $display("FAIL xzr_write: got addr=%h data=%h want 90 0", st_addr_q[0], st_data_q[0]);
      end
      total++;
      if (st_addr_q[1] !== 64'h98 || st_data_q[1] !== 64'd5) begin
         bad++; $display("FAIL xzr_read: got addr=%h data=%h want 98 5", st_addr_q[1], st_data_q[1]);
      end
   endtask

   task automatic test_cbnz();
      logic [63:0] exp_pc  = CBNZ_ON ? 64'h14 : 64'h08;
      logic        exp_ill = !CBNZ_ON;
      int          exp_lat = CBNZ_ON ? 3 : 2;
      reset_dut();
      mem[64'hB0] = 64'd1;
      put(64'h00, d_op(OPC_LDUR, 9'hB0, 5'd31, 5'd5));
      put(64'h04, cb_op(OPC_CBNZ, 19'd4, 5'd5));
      run_retires(2, 100, "cbnz");
      total++;
      if (ret_pc_q[1] !== exp_pc || ret_ill_q[1] !== exp_ill) begin
         bad++; $display("FAIL cbnz: got pc=%h ill=%b want pc=%h ill=%b", ret_pc_q[1], ret_ill_q[1], exp_pc, exp_ill);
      end
      total++;
      if (int'(ret_cyc_q[1] - ret_cyc_q[0]) !== exp_lat) begin
         bad++; $display("FAIL cbnz_latency: got %0d want %0d", int'(ret_cyc_q[1] - ret_cyc_q[0]), exp_lat);
      end
   endtask

   initial begin
      test_reset();
      test_alu_mem();
      test_fetch_wait();
      test_branch();
      test_wrap_illegal();
      test_xzr();
      test_cbnz();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
